// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants and sync-bit types for the scan generator and the drawers.
// Drawers size themselves from xFrameSize/yFrameSize so they cannot drift from the generator.
package vga_sync_gen_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int xFrameSize = H_ACTIVE;
    localparam int yFrameSize = V_ACTIVE;

    localparam int COORD_W = 11;
    localparam int SYNC_W  = 3;

    typedef struct packed {
        logic act;
        logic vs;
        logic hs;
    } sync_bits_t;

    // Idle (deasserted) value of the sync bundle for a given sync polarity.
    function automatic sync_bits_t sync_idle(input logic sync_active);
        sync_idle = '{act: 1'b0, vs: ~sync_active, hs: ~sync_active};
    endfunction

endpackage

// File: rtl/vga_sync_gen_sync_delay_line.sv
// Shift register for the sync bundle: stage 0 captures on the counter edge,
// DEPTH further stages add delay to line up with downstream registered RGB.
module vga_sync_gen_sync_delay_line
    import vga_sync_gen_pkg::*;
#(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = SYNC_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH+1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i <= DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan generator: pixelX/pixelY counters, delayed hsync/vsync/blankN and
// undelayed start-of-frame / end-of-active pulses, all driven from registers.
module vga_sync_gen #(
    parameter int   H_ACTIVE    = vga_sync_gen_pkg::H_ACTIVE,
    parameter int   H_FP        = vga_sync_gen_pkg::H_FP,
    parameter int   H_SYNC      = vga_sync_gen_pkg::H_SYNC,
    parameter int   H_BP        = vga_sync_gen_pkg::H_BP,
    parameter int   V_ACTIVE    = vga_sync_gen_pkg::V_ACTIVE,
    parameter int   V_FP        = vga_sync_gen_pkg::V_FP,
    parameter int   V_SYNC      = vga_sync_gen_pkg::V_SYNC,
    parameter int   V_BP        = vga_sync_gen_pkg::V_BP,
    parameter int   PIPE_DELAY  = 1,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN,
    output logic        startOfFrame,
    output logic        endOfActive
);
    import vga_sync_gen_pkg::*;

    localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST   = 11'(LINE_TOTAL - 1);
    localparam logic [10:0] Y_LAST   = 11'(FRAME_LINES - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] X_EOA    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_EOA    = 11'(V_ACTIVE - 1);

    if (LINE_TOTAL > 2047 || FRAME_LINES > 2047) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_sync_gen: PIPE_DELAY must be within 0..7");
    end

    logic [10:0]       x_q, x_d, y_q, y_d;
    logic              sof_q, sof_d, eoa_q, eoa_d;
    sync_bits_t        raw_d;
    sync_bits_t        dly;
    logic [SYNC_W-1:0] dly_bits;

    always_comb begin
        x_d = x_q + 11'd1;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
        end
    end

    // Decode on the next counter values so stage 0 of the delay line
    // lands on the same edge as the counters themselves.
    always_comb begin
        raw_d.hs  = (x_d >= HS_FIRST && x_d <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw_d.vs  = (y_d >= VS_FIRST && y_d <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw_d.act = (x_d < X_ACT) && (y_d < Y_ACT);
        sof_d     = (x_d == 11'd0) && (y_d == 11'd0);
        eoa_d     = (x_d == X_EOA) && (y_d == Y_EOA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= X_LAST;
            y_q   <= Y_LAST;
            sof_q <= 1'b0;
            eoa_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            sof_q <= sof_d;
            eoa_q <= eoa_d;
        end
    end

    vga_sync_gen_sync_delay_line #(
        .DEPTH     (PIPE_DELAY),
        .WIDTH     (SYNC_W),
        .RESET_VAL (sync_idle(SYNC_ACTIVE))
    ) u_delay (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (raw_d),
        .q_o   (dly_bits)
    );

    assign dly          = dly_bits;
    assign pixelX       = x_q;
    assign pixelY       = y_q;
    assign hsync        = dly.hs;
    assign vsync        = dly.vs;
    assign blankN       = dly.act;
    assign startOfFrame = sof_q;
    assign endOfActive  = eoa_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Produces the pixelX/pixelY scan coordinates consumed by the background, border and object drawers, and the matching VGA hsync/vsync/blank signals.
- Runs on the pixel clock (25.175 MHz nominal for 640x480@60).
- Sync and blank outputs are delayed by a programmable pipeline depth. This keeps them aligned with registered RGB from downstream drawers; the one-stage background drawer needs PIPE_DELAY=1.
- Also emits per-frame pulses for game-logic update timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line (must equal xFrameSize)
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines (must equal yFrameSize)
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 1, clock cycles of delay on hsync/vsync/blankN; legal range 0..7
- SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- pixelX  out  11  horizontal count, 0..H_TOTAL-1
- pixelY  out  11  vertical count, 0..V_TOTAL-1
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- blankN  out  1  delayed active-video flag; 1 = visible pixel
- startOfFrame  out  1  one-cycle pulse when (pixelX,pixelY)=(0,0)
- endOfActive  out  1  one-cycle pulse when (pixelX,pixelY)=(H_ACTIVE-1,V_ACTIVE-1)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values (immediate, asynchronous):
  - pixelX=H_TOTAL-1, pixelY=V_TOTAL-1.
  - hsync=vsync=~SYNC_ACTIVE, blankN=0, startOfFrame=0, endOfActive=0.
  - All delay-stage registers reset to these same deasserted values.
- Counting, one step per clk:
  - pixelX increments each cycle.
  - At pixelX=H_TOTAL-1, pixelX wraps to 0 and pixelY increments.
  - At pixelY=V_TOTAL-1 together with pixelX=H_TOTAL-1, both wrap to 0.
  - The first edge after reset release therefore yields (0,0), and startOfFrame=1 in that cycle.
- All outputs are registered. No combinational path from the counters to the ports.
- Raw sync, evaluated on the current counters:
  - hs_raw active for H_ACTIVE+H_FP <= pixelX <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vs_raw active for V_ACTIVE+V_FP <= pixelY <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
  - act_raw = (pixelX<H_ACTIVE) && (pixelY<V_ACTIVE).
- Delay alignment:
  - hsync/vsync/blankN at cycle t equal hs_raw/vs_raw/act_raw for the counter values present at cycle t-PIPE_DELAY.
  - PIPE_DELAY=0 means they are registered in the same cycle as the counters (same edge).
- Pulses:
  - startOfFrame is high exactly in the cycle where the counters show (0,0).
  - endOfActive is high exactly in the cycle where the counters show (639,479).
  - Pulses are undelayed, i.e. aligned with pixelX/pixelY, not with hsync.
  - Exactly one startOfFrame and one endOfActive per V_TOTAL*H_TOTAL cycles.
- Reset mid-frame: all state returns to reset values immediately. The sequence restarts as after power-up, with no partial sync pulse extended.
- Widths: counters are 11 bit. Parameters must satisfy H_TOTAL, V_TOTAL <= 2047, which is checked by an elaboration assertion.

Decomposition:
- Package defines gains:
  - H_ACTIVE/H_FP/H_SYNC/H_BP and V_* timing constants, plus H_TOTAL/V_TOTAL.
  - xFrameSize/yFrameSize aliased to H_ACTIVE/V_ACTIVE so drawers and generator cannot diverge.
- Sub-module sync_delay_line:
  - Parameterised DEPTH x WIDTH (3-bit) shift register with asynchronous active-high reset to a parameter RESET_VAL.
  - DEPTH=0 is a pass-through of the registered input.

Test Plan:
- Assert reset 3 cycles then release -> first edge gives pixelX=0, pixelY=0, startOfFrame=1; next edge gives pixelX=1, startOfFrame=0.
- Run one line -> pixelX goes 799 to 0 with pixelY 0 to 1. With PIPE_DELAY=1, hsync is low from counter 657 through 752 (96 cycles) when SYNC_ACTIVE=0.
- Run full frame (420000 cycles) -> vsync low for exactly 1600 cycles (lines 490-491 shifted by one clock), blankN high for 307200 cycles, one startOfFrame and one endOfActive, the latter at (639,479).
- PIPE_DELAY=0 and PIPE_DELAY=3 builds -> hsync falling edge observed 0 and 3 cycles respectively after pixelX=656.
- Assert reset when pixelX=700, pixelY=490 (inside hsync and vsync) -> hsync=vsync=1, blankN=0 immediately. After release the sequence matches the power-up run cycle-for-cycle.
- Reduced-timing build (H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1) -> exhaustive check of counter wrap and pulse positions against a reference model for 3 frames.
